pla_chkn_vector_driver: RTL and testbench

Sequential front/back stage wrapped around the combinational `pla__chkn` decoder. It accepts 29-bit input vectors through a valid/ready handshake and buffers them in a small FIFO. Each vector is driven onto the decoder's x00..x28 inputs and held for a programmable settle time. The block then samples z0..z6 and returns the 7-bit result, paired with the vector's tag, through a second valid/ready handshake.

---
 rtl/pla_chkn_vector_driver.sv | 158 +++++++++++++++
 tb/tb_pla_chkn_vector_driver.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/pla_chkn_vector_driver.sv
// Valid/ready front end that queues 29-bit vectors, drives them onto the pla__chkn
// decoder inputs, waits SETTLE cycles, and returns the sampled z with its tag.
module pla_chkn_vector_driver #(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned SETTLE = 2,
  parameter int unsigned TAG_W  = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [28:0]      in_vec,
  input  logic [TAG_W-1:0] in_tag,
  input  logic             flush,
  output logic [28:0]      x,
  input  logic [6:0]       z,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [6:0]       out_z,
  output logic [TAG_W-1:0] out_tag,
  output logic [15:0]      result_count,
  output logic             busy
);

  localparam int unsigned VEC_W = 29;
  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned SET_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;

  typedef struct packed {
    logic [VEC_W-1:0] vec;
    logic [TAG_W-1:0] tag;
  } entry_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    HOLD  = 2'd2
  } state_t;

  state_t             state, state_d;
  entry_t             mem [DEPTH];
  entry_t             head;
  logic [PTR_W-1:0]   wr_ptr, rd_ptr;
  logic [CNT_W-1:0]   fifo_count, fifo_count_d;
  logic [SET_W-1:0]   settle_cnt;
  logic [TAG_W-1:0]   tag_q;
  logic               fifo_empty;
  logic               push_c, pop_c, sample_c, hs_c;

  assign in_ready   = ~rst & (fifo_count != CNT_W'(DEPTH));
  assign fifo_empty = (fifo_count == '0);
  assign head       = mem[rd_ptr];
  // flush wins over a same-cycle push even though in_ready was high
  assign push_c     = in_valid & in_ready & ~flush;
  assign hs_c       = out_valid & out_ready;

  // Next-state and pop/sample decisions
  always_comb begin
    state_d  = state;
    pop_c    = 1'b0;
    sample_c = 1'b0;
    case (state)
      IDLE: begin
        if (!fifo_empty && !flush) begin
          pop_c   = 1'b1;
          state_d = DRIVE;
        end
      end
      DRIVE: begin
        if (settle_cnt == '0) begin
          sample_c = 1'b1;
          state_d  = HOLD;
        end
      end
      HOLD: begin
        if (hs_c) begin
          if (!fifo_empty && !flush) begin
            pop_c   = 1'b1;
            state_d = DRIVE;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    fifo_count_d = fifo_count;
    if (flush) begin
      fifo_count_d = '0;
    end else begin
      fifo_count_d = fifo_count + CNT_W'(push_c) - CNT_W'(pop_c);
    end
  end

  // FIFO storage; contents need no reset since count gates every read
  always_ff @(posedge clk) begin
    if (push_c) begin
      mem[wr_ptr] <= '{vec: in_vec, tag: in_tag};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      fifo_count <= fifo_count_d;
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (push_c) wr_ptr <= wr_ptr + PTR_W'(1);
        if (pop_c)  rd_ptr <= rd_ptr + PTR_W'(1);
      end
    end
  end

  // State register and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      x            <= '0;
      tag_q        <= '0;
      settle_cnt   <= '0;
      out_z        <= '0;
      out_tag      <= '0;
      out_valid    <= 1'b0;
      result_count <= '0;
      busy         <= 1'b0;
    end else begin
      state <= state_d;
      busy  <= (state_d != IDLE) | (fifo_count_d != '0);
      if (pop_c) begin
        x          <= head.vec;
        tag_q      <= head.tag;
        settle_cnt <= SET_W'(SETTLE - 1);
      end else if (state == DRIVE && !sample_c) begin
        settle_cnt <= settle_cnt - SET_W'(1);
      end
      if (sample_c) begin
        out_z     <= z;
        out_tag   <= tag_q;
        out_valid <= 1'b1;
      end else if (hs_c) begin
        out_valid <= 1'b0;
        if (result_count != 16'hFFFF) begin
          result_count <= result_count + 16'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_pla_chkn_vector_driver.sv
// Self-checking bench: directed scenarios plus random traffic against a queue-based
// transaction model; a stand-in decoder function drives z from x.
module tb_pla_chkn_vector_driver;

  localparam int unsigned DEPTH  = 4;
  localparam int unsigned SETTLE = 2;
  localparam int unsigned TAG_W  = 4;

  typedef struct {
    logic [28:0]      v;
    logic [TAG_W-1:0] t;
  } ent_t;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [28:0]      in_vec = '0;
  logic [TAG_W-1:0] in_tag = '0;
  logic             flush = 1'b0;
  logic [28:0]      x;
  logic [6:0]       z;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [6:0]       out_z;
  logic [TAG_W-1:0] out_tag;
  logic [15:0]      result_count;
  logic             busy;

  int checks = 0;
  int errors = 0;

  // model state
  ent_t             q[$];
  bit               m_act;
  int               m_wait;
  logic [28:0]      m_x;
  logic [TAG_W-1:0] m_tag, m_ot;
  logic [6:0]       m_oz;
  bit               m_ov;
  int               m_cnt;

  pla_chkn_vector_driver #(.DEPTH(DEPTH), .SETTLE(SETTLE), .TAG_W(TAG_W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_vec(in_vec),
    .in_tag(in_tag), .flush(flush), .x(x), .z(z), .out_valid(out_valid),
    .out_ready(out_ready), .out_z(out_z), .out_tag(out_tag),
    .result_count(result_count), .busy(busy)
  );

  always #5 clk = ~clk;

  // stand-in decoder: z6 follows x04, the rest is a fold of x
  function automatic logic [6:0] zf(input logic [28:0] v);
    logic [6:0] r;
    r[6]   = v[4];
    r[5:0] = v[5:0] ^ v[11:6] ^ v[17:12] ^ v[23:18] ^ {1'b0, v[28:24]};
    return r;
  endfunction

  assign z = zf(x);

  task automatic chk(input string nm, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", nm, obs, exp);
    end
  endtask

  task automatic model_edge();
    bit   acc, hs, start;
    ent_t e;
    if (rst) begin
      q.delete();
      m_act = 0; m_wait = 0; m_x = '0; m_tag = '0; m_ot = '0; m_oz = '0; m_ov = 0; m_cnt = 0;
    end else begin
      acc   = in_valid && (q.size() != DEPTH) && !flush;
      hs    = m_ov && out_ready;
      start = !flush && (q.size() != 0) && (!m_act || hs);
      if (hs) begin
        m_ov  = 0;
        m_act = 0;
        if (m_cnt < 65535) m_cnt++;
      end else if (m_act && !m_ov) begin
        if (m_wait == 0) begin
          m_oz = zf(m_x);
          m_ot = m_tag;
          m_ov = 1;
        end else begin
          m_wait--;
        end
      end
      if (flush) begin
        q.delete();
      end else begin
        if (start) begin
          e      = q.pop_front();
          m_x    = e.v;
          m_tag  = e.t;
          m_act  = 1;
          m_wait = SETTLE - 1;
        end
        if (acc) begin
          e.v = in_vec;
          e.t = in_tag;
          q.push_back(e);
        end
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    chk("x",            32'(x),            32'(m_x));
    chk("out_valid",    32'(out_valid),    32'(m_ov));
    chk("out_z",        32'(out_z),        32'(m_oz));
    chk("out_tag",      32'(out_tag),      32'(m_ot));
    chk("result_count", 32'(result_count), 32'(m_cnt));
    chk("busy",         32'(busy),         32'(m_act || q.size() != 0));
    chk("in_ready",     32'(in_ready),     32'(!rst && q.size() != DEPTH));
  endtask

  initial begin
    int acc;

    // reset
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    step();

    // single vector, only x04 set
    in_vec = 29'h10; in_tag = 4'h3; in_valid = 1'b1; out_ready = 1'b0;
    step();
    in_valid = 1'b0;
    step();
    chk("single_x", 32'(x), 32'h10);
    step();
    step();
    chk("single_ov",  32'(out_valid), 32'd1);
    chk("single_tag", 32'(out_tag),   32'h3);
    chk("single_z6",  32'(out_z[6]),  32'd1);
    out_ready = 1'b1;
    step();
    chk("single_cnt", 32'(result_count), 32'd1);

    // back-to-back with out_ready high
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_vec = 29'($urandom); in_tag = TAG_W'(i);
      step();
    end
    in_valid = 1'b0;
    repeat (14) step();
    chk("b2b_cnt", 32'(result_count), 32'd5);

    // full FIFO under backpressure
    out_ready = 1'b0;
    acc = 0;
    for (int i = 0; i < 6; i++) begin
      in_valid = 1'b1; in_vec = 29'($urandom); in_tag = TAG_W'(i + 4);
      if (in_ready) acc++;
      step();
    end
    in_valid = 1'b0;
    chk("bp_accepted", 32'(acc), 32'd5);
    chk("bp_in_ready", 32'(in_ready), 32'd0);
    out_ready = 1'b1;
    repeat (20) step();
    chk("bp_cnt", 32'(result_count), 32'd10);

    // flush alongside a push; only the in-flight vector completes
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_vec = 29'($urandom); in_tag = TAG_W'(i);
      step();
    end
    flush = 1'b1; in_vec = 29'($urandom); in_tag = 4'hF;
    step();
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    repeat (10) step();
    chk("flush_cnt",  32'(result_count), 32'd11);
    chk("flush_busy", 32'(busy), 32'd0);

    // reset while a result is held
    out_ready = 1'b0;
    in_valid = 1'b1; in_vec = 29'($urandom); in_tag = 4'h9;
    step();
    in_valid = 1'b0;
    repeat (4) step();
    chk("rst_hold_ov", 32'(out_valid), 32'd1);
    rst = 1'b1;
    step();
    chk("rst_ov",  32'(out_valid),    32'd0);
    chk("rst_x",   32'(x),            32'd0);
    chk("rst_cnt", 32'(result_count), 32'd0);
    rst = 1'b0;
    #1;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    step();

    // random traffic
    for (int i = 0; i < 600; i++) begin
      in_valid  = 1'($urandom_range(0, 1));
      in_vec    = 29'($urandom);
      in_tag    = TAG_W'($urandom);
      out_ready = ($urandom_range(0, 9) < 7);
      flush     = ($urandom_range(0, 19) == 0);
      rst       = ($urandom_range(0, 199) == 0);
      step();
    end
    rst = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    repeat (20) step();

    // saturation: preload the counter near the top, then deliver three results
    force dut.result_count = 16'hFFFE;
    m_cnt = 65534;
    step();
    release dut.result_count;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_vec = 29'($urandom); in_tag = TAG_W'(i);
      step();
    end
    in_valid = 1'b0;
    repeat (12) step();
    chk("sat_cnt", 32'(result_count), 32'hFFFF);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
